// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit and the iterative multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             mult_or_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             erro_div;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, mult_or_div, op_a, op_b,
    input  busy, done, erro_div, hi, lo
  );

  modport slave (
    input  start, mult_or_div, op_a, op_b,
    output busy, done, erro_div, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, one bit per cycle.
// MULT_DIV_FAST_MULT_EN: single-cycle multiply that skips the Booth iteration.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic           clk_i,
  input logic           rst_ni,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             div_q, div_d;
  logic             qm1_q, qm1_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  // acc: Booth partial product high half, or divide partial remainder (one guard bit)
  logic [WIDTH:0]   acc_q, acc_d;
  // mq: Booth multiplier / product low half, or dividend shifting into quotient
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             a_sign, b_sign;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   m_ext, booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_mq;
  logic [WIDTH:0]   shifted, trial, div_acc;
  logic [WIDTH-1:0] div_mq;

`ifdef MULT_DIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = $signed(bus.op_a) * $signed(bus.op_b);
`endif

  assign a_sign = bus.op_a[WIDTH-1];
  assign b_sign = bus.op_b[WIDTH-1];
  assign abs_a  = a_sign ? -bus.op_a : bus.op_a;
  assign abs_b  = b_sign ? -bus.op_b : bus.op_b;

  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_mq  = {booth_sum[0], mq_q[WIDTH-1:1]};

    shifted = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    trial   = shifted - {1'b0, m_q};
    div_acc = trial[WIDTH] ? shifted : trial;
    div_mq  = {mq_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    div_d   = div_q;
    qm1_d   = qm1_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          err_d = 1'b0;
          cnt_d = '0;
          acc_d = '0;
          qm1_d = 1'b0;
          div_d = bus.mult_or_div;
          if (bus.mult_or_div) begin
            if (bus.op_b == '0) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              mq_d    = abs_a;
              m_d     = abs_b;
              qneg_d  = a_sign ^ b_sign;
              rneg_d  = a_sign;
              state_d = StRun;
            end
          end else begin
`ifdef MULT_DIV_FAST_MULT_EN
            hi_d    = fast_prod[2*WIDTH-1:WIDTH];
            lo_d    = fast_prod[WIDTH-1:0];
            state_d = StDone;
`else
            mq_d    = bus.op_b;
            m_d     = bus.op_a;
            state_d = StRun;
`endif
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_q) begin
          acc_d = div_acc;
          mq_d  = div_mq;
        end else begin
          acc_d = booth_acc;
          mq_d  = booth_mq;
          qm1_d = mq_q[0];
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StDone;
          if (div_q) begin
            hi_d = rneg_q ? -div_acc[WIDTH-1:0] : div_acc[WIDTH-1:0];
            lo_d = qneg_q ? -div_mq : div_mq;
          end else begin
            hi_d = booth_acc[WIDTH-1:0];
            lo_d = booth_mq;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      div_q   <= 1'b0;
      qm1_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= '0;
      mq_q    <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      div_q   <= div_d;
      qm1_q   <= qm1_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = (state_q == StDone);
  assign bus.erro_div = (state_q == StDone) && err_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Random + directed bench for mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;
  localparam int unsigned W = 32;
`ifdef MULT_DIV_FAST_MULT_EN
  localparam int MultLat = 0;
`else
  localparam int MultLat = 32;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one outstanding op, its accept edge, its completion edge, pending result.
  bit          m_active = 1'b0;
  int          m_start = 0;
  int          m_end = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      logic e_done;
      logic e_busy;
      e_done = m_active && (cyc == m_end);
      e_busy = m_active && (cyc >= m_start) && (cyc <= m_end);
      chk("done", bus.done, e_done);
      chk("busy", bus.busy, e_busy);
      chk("erro_div", bus.erro_div, e_done & m_err);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
    end
  end

  task automatic model_accept(input bit d, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r, prod;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    m_active = 1'b1;
    m_start  = cyc;
    m_err    = 1'b0;
    if (d) begin
      if (b == 32'd0) begin
        m_err = 1'b1;
        m_end = cyc;
        p_hi  = m_hi;
        p_lo  = m_lo;
      end else begin
        q     = la / lb;
        r     = la % lb;
        p_lo  = q[31:0];
        p_hi  = r[31:0];
        m_end = cyc + 32;
      end
    end else begin
      prod  = la * lb;
      p_hi  = prod[63:32];
      p_lo  = prod[31:0];
      m_end = cyc + MultLat;
    end
  endtask

  // One clock: drive at the falling edge, update the model just after the rising edge.
  task automatic cycle(input bit s, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start       = s;
    bus.mult_or_div = d;
    bus.op_a        = a;
    bus.op_b        = b;
    @(posedge clk);
    #1;
    if (s && rst_n && (!m_active || cyc >= m_end + 2)) model_accept(d, a, b);
    if (m_active && cyc == m_end) begin
      m_hi = p_hi;
      m_lo = p_lo;
    end
  endtask

  task automatic drain();
    while (m_active && cyc < m_end + 1) cycle(1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic op_lit(input string name, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit exp_err,
                        input int exp_lat);
    int  k;
    int  lat;
    bit  seen;
    logic err_s;
    drain();
    cycle(1'b1, d, a, b);
    k     = cyc;
    seen  = 1'b0;
    lat   = -1;
    err_s = 1'b0;
    if (bus.done) begin
      seen  = 1'b1;
      lat   = 0;
      err_s = bus.erro_div;
    end
    for (int i = 1; i <= 40 && !seen; i++) begin
      cycle(1'b0, 1'($urandom), $urandom, $urandom);
      if (bus.done) begin
        seen  = 1'b1;
        lat   = cyc - k;
        err_s = bus.erro_div;
      end
    end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " err"}, err_s, exp_err);
    chk({name, " dut hi"}, bus.hi, exp_hi);
    chk({name, " dut lo"}, bus.lo, exp_lo);
    chk({name, " model hi"}, m_hi, exp_hi);
    chk({name, " model lo"}, m_lo, exp_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      4:       return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    int k;
    int lat;
    bus.start       = 1'b0;
    bus.mult_or_div = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset err", bus.erro_div, 1'b0);
    chk("reset hi", bus.hi, 32'h0);
    chk("reset lo", bus.lo, 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    op_lit("mul 7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MultLat);
    op_lit("mul min^2", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, MultLat);
    op_lit("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
    op_lit("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 32);
    op_lit("div prep", 1'b1, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 32);
    op_lit("div by 0", 1'b1, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 0);

    // Second start during the run must be ignored, giving exactly one done pulse.
    drain();
    cycle(1'b1, 1'b0, 32'h0001_0001, 32'h0001_0001);
    k     = cyc;
    ndone = 0;
    lat   = -1;
    for (int i = 1; i <= 45; i++) begin
      cycle(i == 15, 1'b0, 32'd3, 32'd3);
      if (bus.done) begin
        ndone++;
        lat = cyc - k;
      end
    end
    if (MultLat == 0 && m_active && m_start != k) begin
      // fast multiply finishes before cycle 15, so that start is a legitimate second op
      ndone = ndone - 1;
      lat   = 0;
    end
    chk("b2b done count", ndone, 1);
    chk("b2b latency", lat, MultLat);
    op_lit("b2b next", 1'b0, 32'h0001_0001, 32'h0001_0001, 32'h1, 32'h0002_0001, 1'b0, MultLat);

    // Reset in the middle of a divide aborts it.
    drain();
    cycle(1'b1, 1'b1, 32'd100, 32'd7);
    repeat (9) cycle(1'b0, 1'b0, $urandom, $urandom);
    @(negedge clk);
    chk_en = 1'b0;
    #2;
    rst_n    = 1'b0;
    m_active = 1'b0;
    m_hi     = '0;
    m_lo     = '0;
    #1;
    chk("abort busy", bus.busy, 1'b0);
    chk("abort done", bus.done, 1'b0);
    chk("abort hi", bus.hi, 32'h0);
    chk("abort lo", bus.lo, 32'h0);
    repeat (2) cycle(1'b0, 1'b0, $urandom, $urandom);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (40) cycle(1'b0, 1'b0, $urandom, $urandom);
    op_lit("after reset", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);

    for (int i = 0; i < 2500; i++) begin
      cycle(($urandom % 6) == 0, 1'($urandom), pick(), pick());
    end
    drain();
    repeat (3) cycle(1'b0, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed 32-bit multiply/divide unit.
- Responder to the control unit's MULT/DIV request: the control unit raises start with MultOrDiv, and the unit returns done, ErroDiv and the HI/LO results.
- The control unit copies HI/LO into its HI/LO registers via HIWrite/LOWrite on the done cycle.
- Sits beside the ALU in the datapath; operands come from the A/B registers.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- MultOrDiv  input  1  0 = MULT, 1 = DIV; sampled with start
- A  input  WIDTH  multiplicand / dividend (signed)
- B  input  WIDTH  multiplier / divisor (signed)
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- ErroDiv  output  1  divide-by-zero flag; valid only while done=1
- HI  output  WIDTH  MULT: upper product; DIV: remainder
- LO  output  WIDTH  MULT: lower product; DIV: quotient

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, ErroDiv=0, HI=0, LO=0, counter=0; internal operand registers cleared.
- Reset applied mid-operation aborts the operation; no done pulse is produced for the aborted request.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with MultOrDiv=1 and B=0 -> DONE with ErroDiv=1; HI/LO keep their previous values.
  - start=1 otherwise -> RUN. A, B and MultOrDiv are latched; counter=0.
- RUN: one iteration per cycle; counter increments; after the iteration with counter=WIDTH-1 -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. HI/LO are valid from this cycle and hold until the next completed operation.
- Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH. With WIDTH=32, done is high 33 cycles after the start edge. For divide-by-zero, done is high in the cycle following edge k.
- MULT:
  - Full 2*WIDTH-bit signed product; radix-2 Booth, one bit per cycle.
  - {HI,LO} = A*B in two's complement.
- DIV:
  - Signed divide on magnitudes using restoring division, one quotient bit per cycle.
  - Quotient truncates toward zero. Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
  - Overflow case A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0, ErroDiv=0; no trap is raised.
- start while busy=1 is ignored; it is not queued.
- start and the DONE cycle coinciding: start is ignored, because the unit is not yet in IDLE.
- Operand changes after the start edge have no effect on the result.
- busy is registered; done and ErroDiv are registered and decoded from state.

Optional Feature:
- Macro: MULT_DIV_FAST_MULT_EN.
- Defined:
  - MULT bypasses RUN: {HI,LO} = signed A*B is computed in one cycle, and IDLE goes directly to DONE.
  - done is high in the cycle following the start edge.
  - DIV behaviour is unchanged.
- Undefined: MULT takes the WIDTH-cycle Booth iteration described above.

Test Plan:
- MULT, A=7, B=0xFFFFFFFD (-3) -> done 33 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; ErroDiv=0.
- MULT, A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0x00000000.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV by zero, first with prior HI=0x11, LO=0x22, then A=5, B=0 -> done and ErroDiv high in the cycle after the start edge; HI=0x11, LO=0x22 unchanged; then IDLE.
- Back-to-back: pulse start at cycles 5 and 20 during a MULT -> only one done pulse, at cycle 38 for a start sampled at the cycle-5 edge. The second request started after done gives its correct result.
- Assert reset low at cycle 10 of a DIV -> busy, done, HI and LO go to 0 immediately; no done pulse follows. A new start after reset deasserts completes normally. With MULT_DIV_FAST_MULT_EN defined, repeat the first MULT scenario -> done high in the cycle after the start edge.
